// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART key-event queue.
package spart_pkg;

  localparam int SPART_N_KEYS_DEF = 5;

  typedef logic [SPART_N_KEYS_DEF-1:0] spart_key_t;

  localparam spart_key_t KEY_NONE = '0;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and a view of the newest entry.
// The caller guarantees push is only raised when a slot is free or a pop happens the same cycle.
module spart_sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [WIDTH-1:0]           last_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the caller masks push during reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  assign rdata     = mem[rd_ptr_q];
  assign last_data = mem[wr_ptr_q - PTR_W'(1)];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: rtl/spart_key_queue.sv
// Key-press event queue between the SPART receiver and the CPU key-read path.
// Define SPART_KEY_DEDUP_EN to drop a push that repeats the most recently stored code.
module spart_key_queue
  import spart_pkg::*;
#(
  parameter int N_KEYS = SPART_N_KEYS_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SPART_we,
  input  logic [N_KEYS-1:0]          SPART_keys,
  input  logic                       key_rd,
  output logic [N_KEYS-1:0]          key_out,
  output logic                       key_vld,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

`ifdef SPART_KEY_DEDUP_EN
  localparam bit DEDUP_EN = 1'b1;
`else
  localparam bit DEDUP_EN = 1'b0;
`endif

  logic [N_KEYS-1:0] head_data;
  logic [N_KEYS-1:0] last_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              dup;
  logic              push_cand;
  logic              pop_ok;
  logic              push_ok;
  logic              ovf_set;
  logic              ovf_q;

  // Duplicate check looks at pre-cycle state, even if that entry is popped now.
  assign dup       = DEDUP_EN && !fifo_empty && (SPART_keys == last_data);
  assign push_cand = SPART_we && (SPART_keys != '0) && !dup;
  assign pop_ok    = key_rd && !fifo_empty && !rst;
  assign push_ok   = push_cand && (!fifo_full || pop_ok) && !rst;
  assign ovf_set   = push_cand && fifo_full && !pop_ok;

  spart_sync_fifo #(
    .WIDTH (N_KEYS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .pop       (pop_ok),
    .wdata     (SPART_keys),
    .rdata     (head_data),
    .last_data (last_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign key_vld = !fifo_empty;
  assign key_out = fifo_empty ? '0 : head_data;
  assign full    = fifo_full;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_spart_key_queue.sv
// Directed self-checking bench for spart_key_queue (N_KEYS=5, DEPTH=8).
module tb_spart_key_queue;

  localparam int N_KEYS = 5;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              SPART_we = 1'b0;
  logic [N_KEYS-1:0] SPART_keys = '0;
  logic              key_rd = 1'b0;
  logic              ovf_clr = 1'b0;
  logic [N_KEYS-1:0] key_out;
  logic              key_vld;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  spart_key_queue #(
    .N_KEYS (N_KEYS),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SPART_we   (SPART_we),
    .SPART_keys (SPART_keys),
    .key_rd     (key_rd),
    .key_out    (key_out),
    .key_vld    (key_vld),
    .full       (full),
    .count      (count),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock; inputs are released and outputs sampled 1 time unit after the edge.
  task automatic step(input logic we, input logic [N_KEYS-1:0] k, input logic rd, input logic clr);
    SPART_we   = we;
    SPART_keys = k;
    key_rd     = rd;
    ovf_clr    = clr;
    @(posedge clk);
    #1;
    SPART_we   = 1'b0;
    SPART_keys = '0;
    key_rd     = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  function automatic logic [N_KEYS-1:0] fill_code(input int j);
`ifdef SPART_KEY_DEDUP_EN
    return (j % 2 == 0) ? 5'h10 : 5'h11;
`else
    return 5'h10;
`endif
  endfunction

  initial begin
    logic [N_KEYS-1:0] exp_seq [4];
    int exp_cnt;

    // Reset
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_vld", 32'(key_vld), 0);
    check("rst_key_out", 32'(key_out), 0);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(ovf), 0);

    // Three writes, no reads; valid one cycle after the first write
    step(1, 5'h01, 0, 0);
    check("vld_latency", 32'(key_vld), 1);
    check("head_first", 32'(key_out), 32'h01);
    step(1, 5'h02, 0, 0);
    step(1, 5'h04, 0, 0);
    check("cnt3", 32'(count), 3);
    check("head_01", 32'(key_out), 32'h01);
    check("ovf_none", 32'(ovf), 0);

    // Pop sequence
    exp_seq[0] = 5'h01; exp_seq[1] = 5'h02; exp_seq[2] = 5'h04;
    for (int i = 0; i < 3; i++) begin
      check("pop_order", 32'(key_out), 32'(exp_seq[i]));
      step(0, 0, 1, 0);
    end
    check("drained_vld", 32'(key_vld), 0);
    check("drained_out", 32'(key_out), 0);
    check("drained_cnt", 32'(count), 0);
    step(0, 0, 1, 0);
    check("rd_empty_cnt", 32'(count), 0);

    // Fill to DEPTH, then overflow
    for (int j = 0; j < DEPTH; j++) step(1, fill_code(j), 0, 0);
    check("fill_cnt", 32'(count), DEPTH);
    check("fill_full", 32'(full), 1);
    check("fill_ovf0", 32'(ovf), 0);
    step(1, 5'h01, 0, 0);
    check("ovf_full", 32'(full), 1);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_cnt", 32'(count), DEPTH);
    check("ovf_head", 32'(key_out), 32'h10);
    step(0, 0, 0, 1);
    check("ovf_clr", 32'(ovf), 0);
    // Set beats clear in the same cycle
    step(1, 5'h01, 0, 1);
    check("ovf_set_wins", 32'(ovf), 1);
    step(0, 0, 0, 1);
    check("ovf_clr2", 32'(ovf), 0);

    // Full with simultaneous push and pop
    step(1, 5'h08, 1, 0);
    check("full_rw_cnt", 32'(count), DEPTH);
    check("full_rw_ovf", 32'(ovf), 0);
    for (int j = 0; j < DEPTH; j++) begin
      if (j < DEPTH - 1) check("drain_fill", 32'(key_out), 32'(fill_code(j + 1)));
      else               check("drain_tail08", 32'(key_out), 32'h08);
      step(0, 0, 1, 0);
    end
    check("drain_cnt", 32'(count), 0);

    // Empty with push and pop together: pop ignored
    step(1, 5'h02, 1, 0);
    check("empty_rw_cnt", 32'(count), 1);
    check("empty_rw_out", 32'(key_out), 32'h02);
    step(1, 5'h00, 0, 0);
    check("zero_write", 32'(count), 1);
    check("zero_no_ovf", 32'(ovf), 0);
    step(0, 0, 1, 0);
    check("empty_again", 32'(count), 0);

    // Duplicate suppression
    step(1, 5'h04, 0, 0);
    step(1, 5'h04, 0, 0);
    step(1, 5'h08, 0, 0);
    step(1, 5'h04, 0, 0);
`ifdef SPART_KEY_DEDUP_EN
    exp_cnt = 3;
    exp_seq[0] = 5'h04; exp_seq[1] = 5'h08; exp_seq[2] = 5'h04;
`else
    exp_cnt = 4;
    exp_seq[0] = 5'h04; exp_seq[1] = 5'h04; exp_seq[2] = 5'h08; exp_seq[3] = 5'h04;
`endif
    check("dedup_cnt", 32'(count), 32'(exp_cnt));
    for (int i = 0; i < exp_cnt; i++) begin
      check("dedup_drain", 32'(key_out), 32'(exp_seq[i]));
      step(0, 0, 1, 0);
    end
    check("dedup_empty", 32'(key_vld), 0);

    // Mid-stream reset with count=5; write and read in the reset cycle do nothing
    step(1, 5'h01, 0, 0);
    step(1, 5'h02, 0, 0);
    step(1, 5'h04, 0, 0);
    step(1, 5'h08, 0, 0);
    step(1, 5'h10, 0, 0);
    check("pre_rst_cnt", 32'(count), 5);
    rst = 1'b1;
    step(1, 5'h02, 1, 0);
    rst = 1'b0;
    check("midrst_cnt", 32'(count), 0);
    check("midrst_vld", 32'(key_vld), 0);
    check("midrst_ovf", 32'(ovf), 0);
    check("midrst_out", 32'(key_out), 0);
    step(0, 0, 0, 0);
    check("rst_write_lost", 32'(count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
